multicycle_ctrl: RTL

- Control sequencer for the multi-cycle RV32I core, the successor to the single-cycle control/datapath pair.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB states over one shared memory port with a ready handshake.
- Drives datapath selects, write enables and the ALU control code, and counts retired instructions.
- Parametrised in counter width and number of memory wait cycles tolerated.

---
 rtl/multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Control sequencer for the multi-cycle RV32I core: FETCH/DECODE/EXECUTE/MEM/WB over one memory port.
// Optional macro MC_TIMEOUT_EN bounds memory waits to MEM_TIMEOUT cycles before trapping.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             alu_flag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rs1sel,
  output logic             rs2sel,
  output logic [2:0]       ImmSel,
  output logic [3:0]       ALUControl,
  output logic [2:0]       dmemMode,
  output logic             regWE,
  output logic [1:0]       regsel,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_timeout;

  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic             w_f7b5;
  logic             w_legal;
  logic [2:0]       w_imm_fmt;
  logic             w_is_store;
  logic             w_is_load;
  logic             w_is_jump;
  logic             w_unused;

  assign w_opcode   = instr[6:0];
  assign w_funct3   = instr[14:12];
  assign w_f7b5     = instr[30];
  assign w_is_store = (w_opcode == OP_STORE);
  assign w_is_load  = (w_opcode == OP_LOAD);
  assign w_is_jump  = (w_opcode == OP_JAL) || (w_opcode == OP_JALR);
  // Register indices and most immediate bits belong to the datapath.
  assign w_unused   = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    w_legal   = 1'b1;
    w_imm_fmt = IMM_I;
    case (w_opcode)
      OP_R, OP_IMM, OP_LOAD, OP_JALR: w_imm_fmt = IMM_I;
      OP_STORE:                       w_imm_fmt = IMM_S;
      OP_BRANCH:                      w_imm_fmt = IMM_B;
      OP_LUI, OP_AUIPC:               w_imm_fmt = IMM_U;
      OP_JAL:                         w_imm_fmt = IMM_J;
      default:                        w_legal   = 1'b0;
    endcase
  end

`ifdef MC_TIMEOUT_EN
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  logic [WAIT_W-1:0] r_wait;
  logic              w_waiting;

  // Any completed request clears the count, so each FETCH/MEM visit starts from zero.
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_timeout = w_waiting && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait <= '0;
    end else if (w_waiting) begin
      r_wait <= r_wait + 1'b1;
    end else begin
      r_wait <= '0;
    end
  end
`else
  // Unbounded waits: constant 0 for any legal MEM_TIMEOUT.
  assign w_timeout = (MEM_TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    rs1sel       = 1'b0;
    rs2sel       = 1'b0;
    ImmSel       = 3'd0;
    ALUControl   = 4'd0;
    dmemMode     = 3'd0;
    regWE        = 1'b0;
    regsel       = 2'd0;

    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (w_timeout) begin
          w_state_next = S_TRAP;
        end else if (mem_ready && reset) begin
          ir_we        = 1'b1;
          pc_we        = 1'b1;
          w_state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch/jump target PC+imm is precomputed into the ALU output register.
        rs1sel       = 1'b1;
        rs2sel       = 1'b1;
        ImmSel       = w_imm_fmt;
        w_state_next = w_legal ? S_EXECUTE : S_TRAP;
      end

      S_EXECUTE: begin
        ImmSel = w_imm_fmt;
        case (w_opcode)
          OP_R: begin
            ALUControl   = {w_f7b5, w_funct3};
            w_state_next = S_WB;
          end
          OP_IMM: begin
            ALUControl   = {(w_funct3 == 3'b101) && w_f7b5, w_funct3};
            rs2sel       = 1'b1;
            w_state_next = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            rs2sel       = 1'b1;
            w_state_next = S_MEM;
          end
          OP_BRANCH: begin
            ALUControl = {1'b1, w_funct3};
            if (alu_flag) begin
              pc_we  = 1'b1;
              pc_sel = 2'd1;
            end
            w_retire     = 1'b1;
            w_state_next = S_FETCH;
          end
          OP_JAL: begin
            pc_we        = 1'b1;
            pc_sel       = 2'd1;
            w_state_next = S_WB;
          end
          OP_JALR: begin
            rs2sel       = 1'b1;
            pc_we        = 1'b1;
            pc_sel       = 2'd2;
            w_state_next = S_WB;
          end
          OP_LUI, OP_AUIPC: begin
            rs1sel       = (w_opcode == OP_AUIPC);
            rs2sel       = 1'b1;
            w_state_next = S_WB;
          end
          default: w_state_next = S_TRAP;
        endcase
      end

      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = w_is_store && !w_timeout;
        dmemMode = w_funct3;
        if (w_timeout) begin
          w_state_next = S_TRAP;
        end else if (mem_ready) begin
          if (w_is_store) begin
            w_retire     = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end
      end

      S_WB: begin
        regWE        = 1'b1;
        regsel       = w_is_load ? 2'd1 : (w_is_jump ? 2'd2 : 2'd0);
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end

      S_TRAP: w_state_next = S_TRAP;

      default: w_state_next = S_TRAP;
    endcase
  end

  assign trap    = (r_state == S_TRAP);
  assign retired = r_retired;

endmodule
